// File: rtl/button_step_ctrl.sv
// Button front end for the up/down counter: synchronise, debounce, and turn
// accepted presses into single-cycle step pulses with auto-repeat and conflict lockout.
module button_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 25_000_000,
  parameter int unsigned REPEAT_CYCLES   = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic enable,
  output logic up_down
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned IV_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned IV_W   = $clog2(IV_MAX + 1);
  localparam int unsigned DN     = 0;
  localparam int unsigned UP     = 1;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKOUT} state_t;

  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      db;
  logic [1:0]      db_prev;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;

  state_t          state;
  state_t          state_nx;
  logic [IV_W-1:0] iv_cnt;
  logic [IV_W-1:0] iv_nx;
  logic            held;
  logic            held_nx;
  logic            enable_nx;
  logic            up_down_nx;

  // Two-flop synchronisers and per-button stability counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      s1      <= {btn_up_raw, btn_down_raw};
      s2      <= s1;
      db_prev <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = db & ~db_prev;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      iv_cnt  <= '0;
      held    <= 1'b0;
      enable  <= 1'b0;
      up_down <= 1'b1;
    end else begin
      state   <= state_nx;
      iv_cnt  <= iv_nx;
      held    <= held_nx;
      enable  <= enable_nx;
      up_down <= up_down_nx;
    end
  end

  // Next state; held is 1 when the up button owns the current step sequence
  always_comb begin
    state_nx   = state;
    iv_nx      = iv_cnt;
    held_nx    = held;
    enable_nx  = 1'b0;
    up_down_nx = up_down;
    case (state)
      IDLE: begin
        if (press == 2'b11) begin
          state_nx = LOCKOUT;
        end else if (press != 2'b00) begin
          enable_nx  = 1'b1;
          up_down_nx = press[UP];
          held_nx    = press[UP];
          iv_nx      = IV_W'(HOLD_CYCLES);
          state_nx   = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // Release outranks a simultaneous expiry, so a late repeat never fires
        if (!db[held]) begin
          iv_nx    = '0;
          state_nx = IDLE;
        end else if (press[~held]) begin
          iv_nx    = '0;
          state_nx = LOCKOUT;
        end else if (iv_cnt <= IV_W'(1)) begin
          enable_nx  = 1'b1;
          up_down_nx = held;
          iv_nx      = IV_W'(REPEAT_CYCLES);
          state_nx   = REPEAT;
        end else begin
          iv_nx = iv_cnt - IV_W'(1);
        end
      end
      LOCKOUT: begin
        if (db == 2'b00) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_step_ctrl.sv
// Directed bench for button_step_ctrl with small debounce/hold/repeat settings.
module tb_button_step_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned HC = 10;
  localparam int unsigned RC = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_up_raw;
  logic btn_down_raw;
  logic enable;
  logic up_down;

  button_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .enable      (enable),
    .up_down     (up_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up;
    logic dn;
    logic en;
    logic ud;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_no  = 0;
  int   pulse_edge[$];
  logic pulse_ud[$];
  int   exp_q[$];

  function automatic void add(input logic up, input logic dn, input logic en, input logic ud);
    vec_t v;
    v.up = up;
    v.dn = dn;
    v.en = en;
    v.ud = ud;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample just after the rising edge
  task automatic tick(input logic up, input logic dn);
    @(negedge clk);
    btn_up_raw   = up;
    btn_down_raw = dn;
    @(posedge clk);
    #1;
    edge_no++;
    if (enable === 1'b1) begin
      pulse_edge.push_back(edge_no);
      pulse_ud.push_back(up_down);
    end
  endtask

  task automatic clear_pulses();
    edge_no = 0;
    pulse_edge.delete();
    pulse_ud.delete();
  endtask

  task automatic check_pulses(input string name, input logic exp_ud);
    check({name, " count"}, pulse_edge.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulse_edge.size(); i++) begin
      check($sformatf("%s edge[%0d]", name, i), pulse_edge[i], exp_q[i]);
      check($sformatf("%s up_down[%0d]", name, i), int'(pulse_ud[i]), int'(exp_ud));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    #2;
    check("reset enable", int'(enable), 0);
    check("reset up_down", int'(up_down), 1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    // Clean down press (pulse after edge 7), early release, then up-button bounce
    for (int i = 1; i <= 8; i++) add(1'b0, 1'b1, (i == 7), (i >= 7) ? 1'b0 : 1'b1);
    for (int i = 9; i <= 20; i++) add(1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 1'b0, 1'b0);

    clear_pulses();
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].up, vecs[i].dn);
      check($sformatf("vec%0d enable", i + 1), int'(enable), int'(vecs[i].en));
      check($sformatf("vec%0d up_down", i + 1), int'(up_down), int'(vecs[i].ud));
    end

    // Auto-repeat: up raw high through edge 36, low from edge 37
    clear_pulses();
    for (int i = 1; i <= 56; i++) tick(i <= 36, 1'b0);
    exp_q = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41};
    check_pulses("repeat", 1'b1);

    // Simultaneous press, then up release with down still held
    clear_pulses();
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
    check("lockout held pulses", pulse_edge.size(), 0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    check("lockout release pulses", pulse_edge.size(), 0);

    clear_pulses();
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    exp_q = '{7};
    check_pulses("post-lockout down", 1'b0);

    // Down pressed during up repeat: down accepted at edge 26
    clear_pulses();
    for (int i = 1; i <= 40; i++) tick(1'b1, i >= 21);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    exp_q = '{7, 17, 20, 23, 26};
    check_pulses("second button", 1'b1);

    // Reset while repeating with up held
    clear_pulses();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    check("pre-reset down dir", int'(up_down), 0);
    clear_pulses();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    exp_q = '{7, 17, 20};
    check_pulses("pre-reset repeat", 1'b1);
    check("pulse before reset", int'(enable), 1);
    reset = 1'b1;
    #1;
    check("mid-reset enable", int'(enable), 0);
    check("mid-reset up_down", int'(up_down), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    clear_pulses();
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
    exp_q = '{7};
    check_pulses("after reset", 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_step_ctrl.md
# button_step_ctrl

Upstream control stage for the 4-bit up/down counter: converts two raw, bouncy push-buttons (up, down) into a clean single-cycle `enable` step pulse and a registered `up_down` direction level that the counter samples directly. The block synchronises each button, debounces it, fires one step per accepted press, and auto-repeats while a single button is held. Conflicting presses are locked out.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronised cycles required to accept a level change (20 ms at 50 MHz); must be ≥2.
- `HOLD_CYCLES`, default 25_000_000: cycles from the first step pulse to the first auto-repeat pulse; must be ≥2.
- `REPEAT_CYCLES`, default 5_000_000: cycles between subsequent auto-repeat pulses; must be ≥2.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `btn_up_raw`  in  1  raw up button, asynchronous, active-high, may bounce.
- `btn_down_raw`  in  1  raw down button, asynchronous, active-high, may bounce.
- `enable`  out  1  registered one-cycle step pulse to the counter.
- `up_down`  out  1  registered direction to the counter: 1 = up, 0 = down.

## Operation
- Synchroniser: each raw input passes through two flops (`s1`, `s2`). Nothing downstream uses a raw or `s1` value.
- Debounce, per button: debounced state `db`, plus a stability counter sized by `$clog2(DEBOUNCE_CYCLES)`. The counter increments each cycle while `s2 != db` and clears to 0 on any cycle with `s2 == db`. When the counter equals `DEBOUNCE_CYCLES-1` and `s2 != db`, `db` takes the value of `s2` and the counter clears.
- Press event: the cycle in which `db` goes 0→1. Release: `db` 1→0.
- FSM states and transitions:
  - IDLE:
    - Exactly one press event: emit a step in that direction, load the interval counter with `HOLD_CYCLES`, go to HOLD.
    - Press events on both buttons in the same cycle: no step, go to LOCKOUT.
  - HOLD:
    - Held button released: go to IDLE, no step.
    - Other button's press event: go to LOCKOUT.
    - Interval counter expires: emit a step, reload with `REPEAT_CYCLES`, go to REPEAT.
  - REPEAT:
    - Same as HOLD, except each expiry emits a step and reloads with `REPEAT_CYCLES`.
  - LOCKOUT:
    - No steps.
    - Go to IDLE when both `db` are 0.
- Step emission: `enable` is 1 for exactly one cycle. `up_down` is updated in the same registered cycle to the stepping button's direction: up → 1, down → 0.
- `up_down` holds its value between steps and never changes in a cycle where `enable` = 0, except at reset.
- Reset values: `enable` = 0, `up_down` = 1, both `db` = 0, all `s1`/`s2` = 0, all counters = 0, FSM = IDLE.
- Reset is effective mid-debounce or mid-repeat: all state clears immediately. A button still held when reset deasserts is re-debounced from `db` = 0 and produces a fresh press event.

## Timing
- Press latency: the raw input goes high and stays stable, with its first sampling edge counted as edge 1. `db` rises at edge `DEBOUNCE_CYCLES+2`; `enable` is high in the cycle after edge `DEBOUNCE_CYCLES+3`.
- Release latency: identical, `DEBOUNCE_CYCLES+2` edges to `db` falling. A release accepted before the interval counter expires suppresses that pending repeat.
- Auto-repeat spacing: with the first step pulse at edge E, repeats occur at E+`HOLD_CYCLES`, then at E+`HOLD_CYCLES`+k·`REPEAT_CYCLES`, for k ≥ 1.
- Expiry and release in the same cycle: release wins, no pulse.
- Bounce rejection: any synchronised glitch shorter than `DEBOUNCE_CYCLES` cycles produces no `db` change and no pulse.
- `enable` and `up_down` are both flop outputs: no combinational path from any input.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=3.
- Reset and clean press:
  - Assert `reset` → `enable`=0, `up_down`=1.
  - Release reset, hold `btn_down_raw` high → single `enable` pulse after edge 7, with `up_down`=0 in the same cycle.
- Bounce rejection: toggle `btn_up_raw` high for 3 cycles, then low for 2, repeated 5 times, then release → no `enable` pulse; `up_down` unchanged.
- Auto-repeat: hold `btn_up_raw` for 30 cycles after the first pulse at edge E → pulses at E, E+10, E+13, E+16, …, E+28. Release → pulses stop within 6 edges of the raw fall.
- Conflict:
  - Press both buttons on the same edge → zero pulses.
  - Release up only while down is still held → still zero pulses until both are released.
  - A new down press afterwards → one pulse with `up_down`=0.
- Second button during repeat: hold up into REPEAT, then press down → no further pulses in either direction until both are released.
- Reset mid-repeat: assert `reset` for 1 cycle during REPEAT with up still held → outputs clear immediately; a fresh first pulse follows after debounce (edge 7 after reset release).
